// File: rtl/bcd_updown_counter.sv
// Multi-digit synchronous up/down BCD counter with enable, clear, load,
// wrap/saturate mode and a cascade terminal-count output.
module bcd_updown_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  zero
);

    localparam int unsigned W = 4 * DIGITS;

    logic         all9;
    logic         all0;
    logic         hold;
    logic         carry;
    logic [W-1:0] step_q;
    logic [W-1:0] load_q;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (q[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    assign zero = all0;
    assign tc   = en & ((up & all9) | (~up & all0));
    assign hold = SATURATE & (up ? all9 : all0);

    // Every digit is clamped to 9 before stepping, so invalid codes recover in one step.
    always_comb begin
        step_q = '0;
        load_q = '0;
        carry  = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            logic [3:0] s;
            logic [3:0] ld;
            s  = (q[4*i +: 4] > 4'd9) ? 4'd9 : q[4*i +: 4];
            ld = (d[4*i +: 4] > 4'd9) ? 4'd9 : d[4*i +: 4];
            load_q[4*i +: 4] = ld;
            if (up) begin
                step_q[4*i +: 4] = carry ? ((s == 4'd9) ? 4'd0 : s + 4'd1) : s;
                carry = carry & (s == 4'd9);
            end else begin
                step_q[4*i +: 4] = carry ? ((s == 4'd0) ? 4'd9 : s - 4'd1) : s;
                carry = carry & (s == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_q;
        end else if (en && !hold) begin
            q <= step_q;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: two-digit wrap and saturate instances plus a cascade of
// two one-digit stages, all checked against an integer-arithmetic model.
module tb_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [7:0] d = '0;

    logic [7:0] q_m, q_s;
    logic       tc_m, z_m, tc_s, z_s;
    logic [3:0] q_c0, q_c1;
    logic       tc_c0, tc_c1, z_c0, z_c1;

    logic [7:0] m_main = '0, m_sat = '0, m_casc = '0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .d(d), .q(q_m), .tc(tc_m), .zero(z_m));

    bcd_updown_counter #(.DIGITS(2), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .d(d), .q(q_s), .tc(tc_s), .zero(z_s));

    bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) c0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .d(d[3:0]), .q(q_c0), .tc(tc_c0), .zero(z_c0));

    bcd_updown_counter #(.DIGITS(1), .SATURATE(1'b0)) c1 (
        .clk(clk), .rst(rst), .en(tc_c0), .up(up), .clr(clr), .load(load),
        .d(d[7:4]), .q(q_c1), .tc(tc_c1), .zero(z_c1));

    function automatic int dig(input logic [3:0] x);
        return (x > 4'd9) ? 9 : int'(x);
    endfunction

    // Model: treat the two digits as a decimal number 0..99 and do plain arithmetic.
    function automatic logic [7:0] nxt(input logic [7:0] cur, input bit sat,
                                       input logic c, input logic l, input logic e,
                                       input logic u, input logic [7:0] dd);
        int v;
        if (c) return 8'h00;
        if (l) begin
            v = 10 * dig(dd[7:4]) + dig(dd[3:0]);
        end else if (!e) begin
            return cur;
        end else begin
            v = 10 * dig(cur[7:4]) + dig(cur[3:0]);
            if (u) begin
                if (sat && cur == 8'h99) return cur;
                v = (v + 1) % 100;
            end else begin
                if (sat && cur == 8'h00) return cur;
                v = (v + 99) % 100;
            end
        end
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic exp_tc(input logic [7:0] cur);
        return en & ((up & (cur == 8'h99)) | (~up & (cur == 8'h00)));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_main = '0;
            m_sat  = '0;
            m_casc = '0;
        end else begin
            m_main = nxt(m_main, 1'b0, clr, load, en, up, d);
            m_sat  = nxt(m_sat,  1'b1, clr, load, en, up, d);
            m_casc = nxt(m_casc, 1'b0, clr, load, en, up, d);
        end
    end

    always @(negedge clk) begin
        chk("main_q",    {24'd0, q_m},         {24'd0, m_main});
        chk("main_tc",   {31'd0, tc_m},        {31'd0, exp_tc(m_main)});
        chk("main_zero", {31'd0, z_m},         {31'd0, m_main == 8'h00});
        chk("sat_q",     {24'd0, q_s},         {24'd0, m_sat});
        chk("sat_tc",    {31'd0, tc_s},        {31'd0, exp_tc(m_sat)});
        chk("sat_zero",  {31'd0, z_s},         {31'd0, m_sat == 8'h00});
        chk("casc_q",    {24'd0, q_c1, q_c0},  {24'd0, m_casc});
        chk("casc_tc",   {31'd0, tc_c1},       {31'd0, exp_tc(m_casc)});
        chk("casc_zero", {31'd0, z_c0 & z_c1}, {31'd0, m_casc == 8'h00});
    end

    task automatic step(input logic c, input logic l, input logic e, input logic u,
                        input logic [7:0] dd, input int n);
        clr = c; load = l; en = e; up = u; d = dd;
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("lit_reset_q", {24'd0, q_m}, 32'h00);
        chk("lit_reset_zero", {31'd0, z_m}, 32'h1);
        rst = 1'b1;

        // Up-count from 00: 99 steps land on 99 with tc, one more wraps.
        step(0, 0, 1, 1, 8'h00, 99);
        chk("lit_up_99", {24'd0, q_m}, 32'h99);
        chk("lit_up_tc", {31'd0, tc_m}, 32'h1);
        step(0, 0, 1, 1, 8'h00, 1);
        chk("lit_up_wrap", {24'd0, q_m}, 32'h00);
        chk("lit_up_zero", {31'd0, z_m}, 32'h1);

        // Down-count from 10 through 00 to 99.
        step(0, 1, 0, 0, 8'h10, 1);
        chk("lit_load10", {24'd0, q_m}, 32'h10);
        step(0, 0, 1, 0, 8'h00, 10);
        chk("lit_down_00", {24'd0, q_m}, 32'h00);
        chk("lit_down_tc", {31'd0, tc_m}, 32'h1);
        step(0, 0, 1, 0, 8'h00, 1);
        chk("lit_down_wrap", {24'd0, q_m}, 32'h99);

        // Priority and load sanitisation.
        step(1, 1, 1, 1, 8'h55, 1);
        chk("lit_clr_prio", {24'd0, q_m}, 32'h00);
        step(0, 1, 1, 0, 8'hAF, 1);
        chk("lit_load_AF", {24'd0, q_m}, 32'h99);
        step(0, 1, 0, 1, 8'h3B, 1);
        chk("lit_load_3B", {24'd0, q_m}, 32'h39);

        // Saturate mode.
        step(0, 1, 0, 1, 8'h98, 1);
        step(0, 0, 1, 1, 8'h00, 3);
        chk("lit_sat_hi", {24'd0, q_s}, 32'h99);
        chk("lit_sat_hi_tc", {31'd0, tc_s}, 32'h1);
        chk("lit_wrap_same", {24'd0, q_m}, 32'h01);
        step(0, 1, 0, 0, 8'h01, 1);
        step(0, 0, 1, 0, 8'h00, 2);
        chk("lit_sat_lo", {24'd0, q_s}, 32'h00);
        chk("lit_sat_lo_tc", {31'd0, tc_s}, 32'h1);

        // Invalid digit planted in the register recovers in one step.
        clr = 0; load = 0; en = 1; up = 1;
        force dut.q = 8'h5C;
        m_main = 8'h5C;
        #1 release dut.q;
        @(posedge clk); #2;
        chk("lit_seu_up", {24'd0, q_m}, 32'h60);
        up = 0;
        force dut.q = 8'h5C;
        m_main = 8'h5C;
        #1 release dut.q;
        @(posedge clk); #2;
        chk("lit_seu_down", {24'd0, q_m}, 32'h58);

        // Asynchronous reset between edges.
        step(0, 1, 0, 1, 8'h46, 1);
        step(0, 0, 1, 1, 8'h00, 1);
        chk("lit_pre_rst", {24'd0, q_m}, 32'h47);
        rst = 1'b0;
        #1;
        chk("lit_async_rst", {24'd0, q_m}, 32'h00);
        repeat (2) @(posedge clk);
        #2;
        chk("lit_rst_hold", {24'd0, q_m}, 32'h00);
        rst = 1'b1;

        // Long up-count exercising the cascade every cycle.
        step(1, 0, 0, 1, 8'h00, 1);
        step(0, 0, 1, 1, 8'h00, 120);
        chk("lit_casc_120", {24'd0, q_c1, q_c0}, 32'h20);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit synchronous up/down BCD counter. It generalises the single-digit JK-based up/down BCD counter to DIGITS cascaded decades, and adds:
- count enable
- synchronous clear and parallel load
- selectable wrap or saturate mode
- a cascade terminal-count output for chaining instances

It sits in the counter/timer datapath and drives BCD-to-7-segment display logic.

## Interface
Parameters:
- DIGITS, 2: number of BCD decades (1..8); count width is 4*DIGITS.
- SATURATE, 0: 0 = wrap at bounds; 1 = hold at bounds.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clr  in  1  synchronous clear to zero.
- load  in  1  synchronous parallel load.
- d  in  4*DIGITS  load value; digit i is d[4i+3:4i], and digit 0 is least significant.
- q  out  4*DIGITS  registered count value, same digit packing as d.
- tc  out  1  terminal count, combinational: en & ((up & q==all 9s) | (~up & q==0)).
- zero  out  1  combinational: q == 0.

## Operation
Reset:
- rst low forces q = 0 immediately, independent of clk.
- tc and zero follow from q: zero = 1; tc = en & ~up.
- Deassertion takes effect at the next rising edge.

Per-edge priority (highest first):
1. clr = 1: q <= 0.
2. load = 1: q <= d, with sanitisation. Any loaded digit in 10..15 is stored as 9; valid digits are stored unchanged.
3. en = 1: count one step in the direction given by up.
4. Otherwise: hold.

Increment:
- Digit 0 always steps.
- Digit i steps only when all lower digits are 9.
- A stepping digit goes 9 -> 0; any other digit goes +1.

Decrement:
- Digit 0 always steps.
- Digit i steps only when all lower digits are 0.
- A stepping digit goes 0 -> 9; any other digit goes -1.

Bounds:
- With SATURATE = 0, all 9s + 1 gives 0, and 0 - 1 gives all 9s.
- With SATURATE = 1, incrementing at all 9s holds q, and decrementing at 0 holds q.
- tc asserts at the bound in both modes.

Invalid digits:
- Invalid digits cannot be loaded.
- If an invalid digit (10..15) is present, e.g. after an SEU, the next count step treats it as 9. In the up direction it goes to 0 with carry; in the down direction it goes to 8.
- The counter therefore self-recovers within one enabled step.

Cascading:
- Chain instances by driving the next stage's en from this stage's tc.
- All stages share clk, rst and up.
- tc has no register stage, so a chain behaves as one wider counter.

Direction and control changes:
- Changing up between edges is legal. The new direction applies at the next edge; there is no hidden state.
- clr or load asserted during counting takes effect on that edge. The count step is discarded.

## Timing
- Latency: 1 cycle from a sampled clr/load/en to the updated q.
- q changes only on a rising clk edge, or immediately on rst falling.
- tc and zero are combinational from the registered q, en and up. They are valid within the same cycle, with no added latency.
- The tc path is combinational across DIGITS compares. Keep DIGITS at 8 or fewer per instance.
- Reset asserted mid-count clears q at once. It overrides an edge occurring while rst is low.

## Test plan
DIGITS = 2 unless noted.
- Reset and up-count: rst pulse low, then en = 1, up = 1 for 100 cycles. q steps 00, 01, …, 09, 10, …, 99, 00. tc = 1 exactly in the cycle q = 99. zero = 1 at 00.
- Down-count wrap: load d = 0x10, then en = 1, up = 0. q goes 10, 09, 08, …, 00, 99. tc = 1 only when q = 00.
- Saturate mode: SATURATE = 1, load 0x98, up-count 3 cycles: q goes 99, 99, 99 with tc held at 1. Then down-count from 01: q goes 00, 00.
- Priority and sanitisation: clr = 1, load = 1, en = 1 together gives q = 00. Then load d = 0xAF gives q = 0x99. Then force digit 0 to 0xC with up = 1 and en = 1: the next q has digit 0 = 0 and digit 1 incremented.
- Async reset mid-count: counting up at q = 0x47, drop rst between edges. q = 00 before the next edge and stays 00 while rst is low.
- Cascade: two DIGITS = 1 instances, the second's en = the first's tc. Count up 120 cycles; the combined value matches a DIGITS = 2 instance every cycle.
